// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C master control unit: state encoding,
// SDA acknowledge levels and default widths.
package i2c_pkg;

  localparam int LENGTH      = 8;
  localparam int COUNT_WIDTH = 4;

  localparam logic SDA_ACK  = 1'b0;
  localparam logic SDA_NACK = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SHIFT = 3'd3,
    ST_ACK   = 3'd4,
    ST_STOP  = 3'd5,
    ST_DONE  = 3'd6
  } i2c_state_e;

  // Level the master drives after a received byte: ACK while more bytes follow.
  function automatic logic ack_level(input logic more_bytes);
    return more_bytes ? SDA_ACK : SDA_NACK;
  endfunction

endpackage

// File: rtl/i2c_master_controller_if.sv
// Host/data-unit facing signal bundle of the I2C master control unit.
interface i2c_master_controller_if #(
  parameter int COUNT_WIDTH = i2c_pkg::COUNT_WIDTH
) ();

  logic                   go;
  logic                   read_not_write;
  logic [COUNT_WIDTH-1:0] num_bytes;
  logic                   clock_i2c;
  logic                   ack_in;

  logic                   baud_enable;
  logic                   read_or_write;
  logic                   select;
  logic                   start_stop_ack;
  logic                   shift_or_hold;
  logic                   write_load;
  logic                   next_byte;
  logic                   rx_valid;
  logic                   busy;
  logic                   done;
  logic                   ack_error;

  modport slave (
    input  go, read_not_write, num_bytes, clock_i2c, ack_in,
    output baud_enable, read_or_write, select, start_stop_ack, shift_or_hold,
           write_load, next_byte, rx_valid, busy, done, ack_error
  );

  modport master (
    output go, read_not_write, num_bytes, clock_i2c, ack_in,
    input  baud_enable, read_or_write, select, start_stop_ack, shift_or_hold,
           write_load, next_byte, rx_valid, busy, done, ack_error
  );

endinterface

// File: rtl/i2c_scl_edge_detect.sv
// Single-clock rise/fall pulses of the SCL line from the baud generator.
module i2c_scl_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic scl_i,
  output logic scl_rise_o,
  output logic scl_fall_o
);

  logic scl_q;

  // SCL idles high, so the history register resets high to avoid a false rise.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_q <= 1'b1;
    end else begin
      scl_q <= scl_i;
    end
  end

  assign scl_rise_o = scl_i & ~scl_q;
  assign scl_fall_o = ~scl_i & scl_q;

endmodule

// File: rtl/i2c_master_controller.sv
// Sequences the I2C data unit through START, address byte, data bytes with
// per-byte acknowledge handling, and STOP.
module i2c_master_controller
  import i2c_pkg::*;
#(
  parameter int LENGTH      = i2c_pkg::LENGTH,
  parameter int COUNT_WIDTH = i2c_pkg::COUNT_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  i2c_master_controller_if.slave   bus
);

  localparam int BW = $clog2(LENGTH);
  localparam logic [BW-1:0] BIT_LAST = BW'(LENGTH - 1);

  i2c_state_e             state_q;
  logic                   rnw_q;
  logic [COUNT_WIDTH-1:0] num_q;
  logic [COUNT_WIDTH-1:0] byte_cnt_q;
  logic [BW-1:0]          bit_cnt_q;
  logic                   addr_phase_q;
  logic [1:0]             phase_q;

  logic baud_enable_q, read_or_write_q, select_q, start_stop_ack_q;
  logic shift_or_hold_q, write_load_q, next_byte_q, rx_valid_q;
  logic busy_q, done_q, ack_error_q;

  logic                   scl_rise;
  logic                   scl_fall;
  logic [COUNT_WIDTH-1:0] byte_cnt_d;
  logic                   more_bytes;
  logic                   master_sends_ack;

  i2c_scl_edge_detect u_edge (
    .clk        (clk),
    .rst        (rst),
    .scl_i      (bus.clock_i2c),
    .scl_rise_o (scl_rise),
    .scl_fall_o (scl_fall)
  );

  // Only data bytes advance the byte count; the address pass leaves it alone.
  always_comb begin
    byte_cnt_d = byte_cnt_q;
    if (!addr_phase_q && (byte_cnt_q != {COUNT_WIDTH{1'b1}})) begin
      byte_cnt_d = byte_cnt_q + 1'b1;
    end else begin
      byte_cnt_d = byte_cnt_q;
    end
    more_bytes       = (byte_cnt_d < num_q);
    master_sends_ack = rnw_q & ~addr_phase_q;
  end

  // Transaction FSM with registered bus-control and status outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= ST_IDLE;
      rnw_q            <= 1'b0;
      num_q            <= '0;
      byte_cnt_q       <= '0;
      bit_cnt_q        <= '0;
      addr_phase_q     <= 1'b0;
      phase_q          <= 2'd0;
      baud_enable_q    <= 1'b0;
      read_or_write_q  <= 1'b0;
      select_q         <= 1'b1;
      start_stop_ack_q <= 1'b1;
      shift_or_hold_q  <= 1'b0;
      write_load_q     <= 1'b0;
      next_byte_q      <= 1'b0;
      rx_valid_q       <= 1'b0;
      busy_q           <= 1'b0;
      done_q           <= 1'b0;
      ack_error_q      <= 1'b0;
    end else begin
      write_load_q <= 1'b0;
      next_byte_q  <= 1'b0;
      rx_valid_q   <= 1'b0;
      done_q       <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (bus.go) begin
            rnw_q         <= bus.read_not_write;
            num_q         <= bus.num_bytes;
            ack_error_q   <= 1'b0;
            baud_enable_q <= 1'b1;
            busy_q        <= 1'b1;
            byte_cnt_q    <= '0;
            bit_cnt_q     <= '0;
            addr_phase_q  <= 1'b1;
            phase_q       <= 2'd0;
            state_q       <= ST_START;
          end
        end
        ST_START: begin
          if (scl_rise && (phase_q == 2'd0)) begin
            start_stop_ack_q <= SDA_ACK;
            phase_q          <= 2'd1;
          end else if (scl_fall && (phase_q == 2'd1)) begin
            state_q <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          write_load_q    <= 1'b1;
          select_q        <= 1'b0;
          bit_cnt_q       <= '0;
          read_or_write_q <= rnw_q & ~addr_phase_q;
          shift_or_hold_q <= 1'b1;
          state_q         <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (scl_fall) begin
            if (bit_cnt_q == BIT_LAST) begin
              shift_or_hold_q <= 1'b0;
              select_q        <= 1'b1;
              state_q         <= ST_ACK;
              if (master_sends_ack) begin
                read_or_write_q  <= 1'b0;
                rx_valid_q       <= 1'b1;
                start_stop_ack_q <= ack_level(more_bytes);
              end else begin
                read_or_write_q <= 1'b1;
              end
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        ST_ACK: begin
          if (scl_rise && !master_sends_ack) begin
            if (bus.ack_in) begin
              // SCL is high here: keep SDA released until it falls again.
              ack_error_q <= 1'b1;
              phase_q     <= 2'd0;
              state_q     <= ST_STOP;
            end else if (!rnw_q && more_bytes) begin
              next_byte_q <= 1'b1;
            end
          end else if (scl_fall) begin
            byte_cnt_q   <= byte_cnt_d;
            addr_phase_q <= 1'b0;
            if (more_bytes) begin
              state_q <= ST_LOAD;
            end else begin
              select_q         <= 1'b1;
              read_or_write_q  <= 1'b0;
              start_stop_ack_q <= 1'b0;
              phase_q          <= 2'd1;
              state_q          <= ST_STOP;
            end
          end
        end
        ST_STOP: begin
          case (phase_q)
            2'd0: begin
              if (scl_fall) begin
                select_q         <= 1'b1;
                read_or_write_q  <= 1'b0;
                start_stop_ack_q <= 1'b0;
                phase_q          <= 2'd1;
              end
            end
            2'd1: begin
              if (scl_rise) begin
                start_stop_ack_q <= 1'b1;
                phase_q          <= 2'd2;
              end
            end
            2'd2: begin
              if (scl_fall) begin
                baud_enable_q <= 1'b0;
                busy_q        <= 1'b0;
                done_q        <= 1'b1;
                state_q       <= ST_DONE;
              end
            end
            default: begin
              phase_q <= 2'd0;
            end
          endcase
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.baud_enable    = baud_enable_q;
  assign bus.read_or_write  = read_or_write_q;
  assign bus.select         = select_q;
  assign bus.start_stop_ack = start_stop_ack_q;
  assign bus.shift_or_hold  = shift_or_hold_q;
  assign bus.write_load     = write_load_q;
  assign bus.next_byte      = next_byte_q;
  assign bus.rx_valid       = rx_valid_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.ack_error      = ack_error_q;

endmodule

// File: tb/tb_i2c_master_controller.sv
// Self-checking bench for i2c_master_controller with a simple SCL generator
// model and scoreboard queues for master ACK levels and completion status.
module tb_i2c_master_controller;
  import i2c_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  i2c_master_controller_if bus ();

  i2c_master_controller #(.LENGTH(8), .COUNT_WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int vectors     = 0;
  int miscompares = 0;
  int cnt_wl = 0, cnt_nb = 0, cnt_rx = 0, cnt_done = 0;
  logic exp_ssa_q[$];
  logic exp_err_q[$];

  // Baud generator model: SCL idles high, toggles every 4 clocks when enabled.
  logic [2:0] div = 3'd0;
  always @(negedge clk) begin
    if (!bus.baud_enable) begin
      bus.clock_i2c <= 1'b1;
      div <= 3'd0;
    end else if (div == 3'd3) begin
      bus.clock_i2c <= ~bus.clock_i2c;
      div <= 3'd0;
    end else begin
      div <= div + 3'd1;
    end
  end

  // Frame tracking between the START condition and the start of STOP.
  logic prev_ssa = 1'b1, prev_scl = 1'b1, in_frame = 1'b0, frame_wl = 1'b0;
  int   frame_rises = 0, last_rises = -1;

  // Pulse counters and scoreboard checks on DUT output events.
  always @(negedge clk) begin
    logic e;
    if (bus.write_load) cnt_wl++;
    if (bus.next_byte)  cnt_nb++;
    if (bus.rx_valid) begin
      cnt_rx++;
      vectors++;
      if (exp_ssa_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_ack_level: RxValid seen, no expected ACK level queued");
      end else begin
        e = exp_ssa_q.pop_front();
        if ({bus.select, bus.read_or_write, bus.start_stop_ack} !== {1'b1, 1'b0, e}) begin
          miscompares++;
          $display("FAIL rx_ack_level: got sel/row/sda=%b%b%b expected 10%b",
                   bus.select, bus.read_or_write, bus.start_stop_ack, e);
        end
      end
    end
    if (bus.done) begin
      cnt_done++;
      vectors++;
      if (exp_err_q.size() == 0) begin
        miscompares++;
        $display("FAIL done_status: Done seen, no transaction expected");
      end else begin
        e = exp_err_q.pop_front();
        if ({bus.busy, bus.ack_error} !== {1'b0, e}) begin
          miscompares++;
          $display("FAIL done_status: got busy/ack_error=%b%b expected 0%b",
                   bus.busy, bus.ack_error, e);
        end
      end
    end
    if (rst) begin
      in_frame = 1'b0;
    end else if (!in_frame && bus.baud_enable && bus.select && prev_ssa &&
                 !bus.start_stop_ack && bus.clock_i2c) begin
      in_frame    = 1'b1;
      frame_wl    = 1'b0;
      frame_rises = 0;
    end else if (in_frame) begin
      if (bus.write_load) frame_wl = 1'b1;
      if (bus.clock_i2c && !prev_scl) frame_rises++;
      if (frame_wl && bus.select && !bus.read_or_write && !bus.start_stop_ack) begin
        in_frame   = 1'b0;
        last_rises = frame_rises;
      end
    end
    prev_ssa = bus.start_stop_ack;
    prev_scl = bus.clock_i2c;
  end

  task automatic start_txn(input logic rnw, input logic [3:0] n, input logic nack);
    @(negedge clk);
    bus.read_not_write = rnw;
    bus.num_bytes      = n;
    bus.ack_in         = nack;
    bus.go             = 1'b1;
    exp_err_q.push_back(nack);
    if (rnw && !nack) begin
      for (int i = 0; i < int'(n); i++) begin
        exp_ssa_q.push_back((i == int'(n) - 1) ? SDA_NACK : SDA_ACK);
      end
    end
    @(negedge clk);
    bus.go = 1'b0;
    vectors++;
    if ({bus.busy, bus.ack_error} !== 2'b10) begin
      miscompares++;
      $display("FAIL go_accept: got busy/ack_error=%b%b expected 10", bus.busy, bus.ack_error);
    end
  endtask

  task automatic wait_done(input int base, input string name);
    int k;
    for (k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (cnt_done != base) break;
    end
    if (k == 3000) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: Done not seen within 3000 cycles", name);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    vectors++;
    if ({bus.baud_enable, bus.read_or_write, bus.select, bus.start_stop_ack,
         bus.shift_or_hold, bus.write_load, bus.next_byte, bus.rx_valid,
         bus.busy, bus.done, bus.ack_error} !== 11'b00110000000) begin
      miscompares++;
      $display("FAIL reset_outputs: got %b expected 00110000000",
               {bus.baud_enable, bus.read_or_write, bus.select, bus.start_stop_ack,
                bus.shift_or_hold, bus.write_load, bus.next_byte, bus.rx_valid,
                bus.busy, bus.done, bus.ack_error});
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_write();
    int wl0 = cnt_wl, nb0 = cnt_nb, d0 = cnt_done;
    start_txn(1'b0, 4'd2, 1'b0);
    wait_done(d0, "write");
    repeat (5) @(negedge clk);
    vectors++;
    if ({cnt_wl - wl0, cnt_nb - nb0, cnt_done - d0} !== {32'd3, 32'd2, 32'd1}) begin
      miscompares++;
      $display("FAIL write_pulses: got wl=%0d nb=%0d done=%0d expected 3 2 1",
               cnt_wl - wl0, cnt_nb - nb0, cnt_done - d0);
    end
  endtask

  task automatic test_read();
    int wl0 = cnt_wl, rx0 = cnt_rx, nb0 = cnt_nb, d0 = cnt_done;
    start_txn(1'b1, 4'd3, 1'b0);
    wait_done(d0, "read");
    vectors++;
    if ({cnt_rx - rx0, cnt_wl - wl0, cnt_nb - nb0} !== {32'd3, 32'd4, 32'd0}) begin
      miscompares++;
      $display("FAIL read_pulses: got rx=%0d wl=%0d nb=%0d expected 3 4 0",
               cnt_rx - rx0, cnt_wl - wl0, cnt_nb - nb0);
    end
    vectors++;
    if (exp_ssa_q.size() != 0) begin
      miscompares++;
      $display("FAIL read_ack_levels: %0d expected RxValid events not seen", exp_ssa_q.size());
    end
  endtask

  task automatic test_addr_nack();
    int wl0 = cnt_wl, nb0 = cnt_nb, d0 = cnt_done;
    start_txn(1'b0, 4'd2, 1'b1);
    wait_done(d0, "nack");
    repeat (3) @(negedge clk);
    vectors++;
    if ({cnt_wl - wl0, cnt_nb - nb0, bus.ack_error} !== {32'd1, 32'd0, 1'b1}) begin
      miscompares++;
      $display("FAIL nack_abort: got wl=%0d nb=%0d ack_error=%b expected 1 0 1",
               cnt_wl - wl0, cnt_nb - nb0, bus.ack_error);
    end
    d0 = cnt_done;
    wl0 = cnt_wl;
    start_txn(1'b0, 4'd1, 1'b0);
    wait_done(d0, "after_nack");
    vectors++;
    if (cnt_wl - wl0 != 2) begin
      miscompares++;
      $display("FAIL after_nack_wl: got %0d expected 2", cnt_wl - wl0);
    end
  endtask

  task automatic test_addr_only();
    int wl0 = cnt_wl, nb0 = cnt_nb, d0 = cnt_done;
    last_rises = -1;
    start_txn(1'b0, 4'd0, 1'b0);
    wait_done(d0, "addr_only");
    vectors++;
    if ({cnt_wl - wl0, cnt_nb - nb0, last_rises} !== {32'd1, 32'd0, 32'd9}) begin
      miscompares++;
      $display("FAIL addr_only: got wl=%0d nb=%0d scl_rises=%0d expected 1 0 9",
               cnt_wl - wl0, cnt_nb - nb0, last_rises);
    end
  endtask

  task automatic test_reset_mid();
    int wl0 = cnt_wl, d0 = cnt_done, k;
    start_txn(1'b0, 4'd2, 1'b0);
    for (k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (cnt_wl - wl0 >= 3) break;
    end
    vectors++;
    if (k == 2000) begin
      miscompares++;
      $display("FAIL reset_mid_reach: third WriteLoad not seen");
    end
    repeat (12) @(negedge clk);
    rst = 1'b1;
    void'(exp_err_q.pop_back());
    @(negedge clk);
    vectors++;
    if ({bus.baud_enable, bus.read_or_write, bus.select, bus.start_stop_ack,
         bus.shift_or_hold, bus.write_load, bus.next_byte, bus.rx_valid,
         bus.busy, bus.done, bus.ack_error, cnt_done - d0} !== {11'b00110000000, 32'd0}) begin
      miscompares++;
      $display("FAIL reset_mid_outputs: got %b done_count=%0d expected 00110000000 0",
               {bus.baud_enable, bus.read_or_write, bus.select, bus.start_stop_ack,
                bus.shift_or_hold, bus.write_load, bus.next_byte, bus.rx_valid,
                bus.busy, bus.done, bus.ack_error}, cnt_done - d0);
    end
    rst = 1'b0;
    repeat (3) @(negedge clk);
    wl0 = cnt_wl;
    d0 = cnt_done;
    start_txn(1'b0, 4'd1, 1'b0);
    wait_done(d0, "post_reset");
    vectors++;
    if (cnt_wl - wl0 != 2) begin
      miscompares++;
      $display("FAIL post_reset_wl: got %0d expected 2", cnt_wl - wl0);
    end
  endtask

  task automatic test_back_to_back_go();
    int wl0 = cnt_wl, d0 = cnt_done;
    start_txn(1'b0, 4'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      repeat (20) @(negedge clk);
      bus.num_bytes = 4'd5;
      bus.go = 1'b1;
      @(negedge clk);
      bus.go = 1'b0;
    end
    wait_done(d0, "busy_go");
    repeat (200) @(negedge clk);
    vectors++;
    if ({cnt_done - d0, cnt_wl - wl0, 31'd0, bus.busy} !== {32'd1, 32'd2, 32'd0}) begin
      miscompares++;
      $display("FAIL busy_go_ignored: got done=%0d wl=%0d busy=%b expected 1 2 0",
               cnt_done - d0, cnt_wl - wl0, bus.busy);
    end
  endtask

  initial begin
    bus.go             = 1'b0;
    bus.read_not_write = 1'b0;
    bus.num_bytes      = 4'd0;
    bus.ack_in         = 1'b0;
    test_reset();
    test_write();
    test_read();
    test_addr_nack();
    test_addr_only();
    test_reset_mid();
    test_back_to_back_go();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
